mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter STEP, default 8, multiplier bits retired per cycle; XLEN % STEP == 0 SHALL hold, elaboration error otherwise.
REQ-003 Parameter TAG_W, default 5, width of the pass-through tag.
REQ-004 clk  input  1  clock; single clock domain, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 op  input  2  00 MUL (low half), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high).
REQ-009 a, b  input  XLEN each  operands; a is multiplicand, b is multiplier.
REQ-010 tag_in  input  TAG_W  opaque tag, returned with the result.
REQ-011 flush  input  1  abandon any in-flight operation.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  XLEN  selected product half.
REQ-015 tag_out  output  TAG_W  tag of the request that produced result.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, DONE; N = XLEN/STEP.
REQ-017 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush; op, sign-corrected magnitudes, result sign, and tag are latched, and the FSM enters CALC with step counter 0.
REQ-018 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready) and SHALL be 0 in CALC.
REQ-019 Each CALC cycle SHALL add the STEP partial products selected by the next STEP multiplier bits (LSB first) into a 2*XLEN carry-save accumulator.
REQ-020 After the Nth CALC cycle the FSM SHALL resolve the carry-save sum, conditionally negate the 2*XLEN product, register result/tag_out, and enter DONE.
REQ-021 out_valid SHALL be 1 exactly in DONE, first asserted N+1 cycles after the accepting edge (5 cycles at XLEN=32, STEP=8).
REQ-022 Signedness: a is signed for MULH/MULHSU, b is signed only for MULH; the magnitude of the most negative value SHALL be represented unsigned in XLEN bits, so no overflow case exists for any op.
REQ-023 Result sign SHALL be (a signed && a[XLEN-1]) XOR (b signed && b[XLEN-1]); MUL returns bits [XLEN-1:0], other ops return bits [2XLEN-1:XLEN].
REQ-024 In DONE with out_ready=0, result, tag_out and out_valid SHALL hold stable.
REQ-025 In DONE with out_ready=1 and a new accept in the same cycle, the FSM SHALL go directly to CALC (back-to-back, no idle bubble); otherwise it goes to IDLE.
REQ-026 flush SHALL take priority over all other inputs: next state IDLE, out_valid 0 next cycle, no accept that cycle.

Reset
REQ-027 On rst assertion, without waiting for clk: state IDLE, out_valid 0, in_ready 1, result 0, tag_out 0, counter and accumulator 0.
REQ-028 Reset mid-CALC or in DONE SHALL discard the operation; no result SHALL appear after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU) and the FSM state enum.
REQ-030 One sub-module mul_csa_step SHALL implement the combinational STEP-row partial-product carry-save compression for one cycle, parameterised by XLEN and STEP.
REQ-031 Only the final carry-propagate add and negation SHALL use a full-width adder.

Verification
REQ-032 MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> 0x00000001; out_valid at cycle 5.
REQ-033 MULH a=0x80000000 b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFF; MUL a=0xFFFFFFFF b=0x00000002 -> 0xFFFFFFFE.
REQ-034 out_ready held 0 for 3 cycles in DONE -> result/tag_out stable; then out_ready=1 with in_valid=1 -> accept same edge, next out_valid 5 cycles later.
REQ-035 flush at CALC cycle 2 -> out_valid never asserts for that tag, in_ready=1 next cycle; rst asserted mid-CALC between edges -> outputs return to reset values immediately.
REQ-036 Random ops/operands versus a 2*XLEN reference model for (XLEN,STEP) = (32,8), (32,1), (32,32), (16,4).

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential multiplier: op encodings, FSM states,
// and operand signedness decode.
package mul_seq_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        MUL_ST_IDLE = 2'd0,
        MUL_ST_CALC = 2'd1,
        MUL_ST_DONE = 2'd2
    } mul_state_e;

    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mul_seq_csa_step.sv
// One iteration of the multiplier datapath: STEP partial-product rows folded
// into a 2*XLEN carry-save pair with 3:2 compressors (no carry propagation).
module mul_csa_step #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic [2*XLEN-1:0] i_sum,
    input  logic [2*XLEN-1:0] i_carry,
    input  logic [2*XLEN-1:0] i_mcand,
    input  logic [STEP-1:0]   i_bits,
    output logic [2*XLEN-1:0] o_sum,
    output logic [2*XLEN-1:0] o_carry
);

    localparam int W = 2 * XLEN;

    logic [W-1:0] w_pp [STEP];

    genvar gi;
    generate
        for (gi = 0; gi < STEP; gi++) begin : g_pp
            assign w_pp[gi] = i_bits[gi] ? (i_mcand << gi) : '0;
        end
    endgenerate

    // Carries leaving bit W-1 are dropped: the final product always fits in W bits.
    always_comb begin
        logic [W-1:0] w_s;
        logic [W-1:0] w_c;
        logic [W-1:0] w_t;
        w_s = i_sum;
        w_c = i_carry;
        w_t = '0;
        for (int i = 0; i < STEP; i++) begin
            w_t = w_s ^ w_c ^ w_pp[i];
            w_c = ((w_s & w_c) | (w_s & w_pp[i]) | (w_c & w_pp[i])) << 1;
            w_s = w_t;
        end
        o_sum   = w_s;
        o_carry = w_c;
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential sign-magnitude multiplier retiring STEP multiplier bits per cycle,
// with a valid/ready request side, flush, and a pass-through tag.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEP  = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int N     = XLEN / STEP;
    localparam int CNT_W = $clog2(N + 1);

    generate
        if (XLEN % STEP != 0) begin : g_bad_step
            $error("mul_seq: XLEN must be a multiple of STEP");
        end
    endgenerate

    mul_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_sum;
    logic [2*XLEN-1:0]   r_carry;
    logic                r_neg;
    logic [1:0]          r_op;
    logic [TAG_W-1:0]    r_tag;

    logic                w_accept;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [2*XLEN-1:0]   w_step_sum;
    logic [2*XLEN-1:0]   w_step_carry;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;

    assign in_ready  = (r_state == MUL_ST_IDLE) || ((r_state == MUL_ST_DONE) && out_ready);
    assign out_valid = (r_state == MUL_ST_DONE);
    assign w_accept  = in_valid && in_ready && !flush;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    assign w_a_neg = op_a_signed(op) && a[XLEN-1];
    assign w_b_neg = op_b_signed(op) && b[XLEN-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    mul_csa_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .i_sum   (r_sum),
        .i_carry (r_carry),
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[STEP-1:0]),
        .o_sum   (w_step_sum),
        .o_carry (w_step_carry)
    );

    assign w_prod     = r_sum + r_carry;
    assign w_prod_fix = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MUL_ST_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sum    <= '0;
            r_carry  <= '0;
            r_neg    <= 1'b0;
            r_op     <= MUL_OP_MUL;
            r_tag    <= '0;
            result   <= '0;
            tag_out  <= '0;
        end else if (flush) begin
            r_state <= MUL_ST_IDLE;
        end else if (w_accept) begin
            r_state  <= MUL_ST_CALC;
            r_cnt    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_sum    <= '0;
            r_carry  <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_op     <= op;
            r_tag    <= tag_in;
        end else begin
            case (r_state)
                MUL_ST_CALC: begin
                    if (r_cnt == CNT_W'(N)) begin
                        result  <= (r_op == MUL_OP_MUL) ? w_prod_fix[XLEN-1:0]
                                                        : w_prod_fix[2*XLEN-1:XLEN];
                        tag_out <= r_tag;
                        r_state <= MUL_ST_DONE;
                    end else begin
                        r_sum    <= w_step_sum;
                        r_carry  <= w_step_carry;
                        r_mcand  <= r_mcand << STEP;
                        r_mplier <= r_mplier >> STEP;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                MUL_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= MUL_ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Checks four mul_seq configurations against a queue-based arithmetic model:
// directed corner products on (32,8), then randomized traffic on every configuration.
module tb_mul_seq;
    import mul_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          rdy;
        bit          lit_en;
        logic [31:0] lit;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  fl;
    logic [3:0]  ordy;
    logic [1:0]  op_s   [4];
    logic [31:0] a_s    [4];
    logic [31:0] b_s    [4];
    logic [4:0]  tag_s  [4];
    logic [3:0]  in_ready_w;
    logic [3:0]  out_valid_w;
    logic [31:0] result_w [4];
    logic [4:0]  tag_w    [4];
    logic [15:0] res3;

    bit          lit_en;
    logic [31:0] lit_val;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q [4][$];

    mul_seq #(.XLEN(32), .STEP(8), .TAG_W(5)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(in_ready_w[0]), .op(op_s[0]),
        .a(a_s[0]), .b(b_s[0]), .tag_in(tag_s[0]), .flush(fl[0]), .out_valid(out_valid_w[0]),
        .out_ready(ordy[0]), .result(result_w[0]), .tag_out(tag_w[0]));

    mul_seq #(.XLEN(32), .STEP(1), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(in_ready_w[1]), .op(op_s[1]),
        .a(a_s[1]), .b(b_s[1]), .tag_in(tag_s[1]), .flush(fl[1]), .out_valid(out_valid_w[1]),
        .out_ready(ordy[1]), .result(result_w[1]), .tag_out(tag_w[1]));

    mul_seq #(.XLEN(32), .STEP(32), .TAG_W(5)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(in_ready_w[2]), .op(op_s[2]),
        .a(a_s[2]), .b(b_s[2]), .tag_in(tag_s[2]), .flush(fl[2]), .out_valid(out_valid_w[2]),
        .out_ready(ordy[2]), .result(result_w[2]), .tag_out(tag_w[2]));

    mul_seq #(.XLEN(16), .STEP(4), .TAG_W(5)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(in_ready_w[3]), .op(op_s[3]),
        .a(a_s[3][15:0]), .b(b_s[3][15:0]), .tag_in(tag_s[3]), .flush(fl[3]),
        .out_valid(out_valid_w[3]), .out_ready(ordy[3]), .result(res3), .tag_out(tag_w[3]));

    assign result_w[3] = {16'd0, res3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_x(input int k);
        return (k == 3) ? 16 : 32;
    endfunction

    function automatic int cfg_n(input int k);
        case (k)
            0:       return 4;
            1:       return 32;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Exact product of the operands interpreted per op, then the requested half.
    function automatic logic [31:0] ref_mul(input int xl, input logic [1:0] o,
                                            input logic [31:0] av, input logic [31:0] bv);
        logic signed [127:0] sa, sb, p;
        logic [127:0] mask, r;
        mask = (128'd1 << xl) - 128'd1;
        sa = av & mask;
        sb = bv & mask;
        if ((o == MUL_OP_MULH || o == MUL_OP_MULHSU) && av[xl-1]) sa = sa - (128'd1 << xl);
        if ((o == MUL_OP_MULH) && bv[xl-1]) sb = sb - (128'd1 << xl);
        p = sa * sb;
        r = (o == MUL_OP_MUL) ? (p & mask) : ((p >> xl) & mask);
        return r[31:0];
    endfunction

    function automatic bit mvalid(input int k);
        return (q[k].size() > 0) && (cyc >= q[k][0].rdy);
    endfunction

    function automatic bit mready(input int k);
        return (q[k].size() == 0) || (mvalid(k) && ordy[k]);
    endfunction

    // Model: at most one request per unit; result visible N+1 edges after acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (fl[k]) begin
                    q[k].delete();
                end else if (vld[k] && mready(k)) begin
                    if (q[k].size() > 0) void'(q[k].pop_front());
                    q[k].push_back('{ref_mul(cfg_x(k), op_s[k], a_s[k], b_s[k]), tag_s[k],
                                     cyc + cfg_n(k) + 2, lit_en, lit_val});
                end else if (mvalid(k) && ordy[k]) begin
                    void'(q[k].pop_front());
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cfg%0d t=%0t: got %h required %h", name, k, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", k, 32'(out_valid_w[k]), 32'(mvalid(k)));
            chk("in_ready", k, 32'(in_ready_w[k]), 32'(mready(k)));
            if (mvalid(k)) begin
                chk("result", k, result_w[k], q[k][0].res);
                chk("tag_out", k, 32'(tag_w[k]), 32'(q[k][0].tag));
                if (q[k][0].lit_en) begin
                    chk("model_pin", k, q[k][0].res, q[k][0].lit);
                    chk("result_lit", k, result_w[k], q[k][0].lit);
                end
            end
            if (rst) begin
                chk("rst_result", k, result_w[k], 32'd0);
                chk("rst_tag", k, 32'(tag_w[k]), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dreq(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] t, input bit le, input logic [31:0] lv);
        vld[0]   = 1'b1;
        op_s[0]  = o;
        a_s[0]   = av;
        b_s[0]   = bv;
        tag_s[0] = t;
        lit_en   = le;
        lit_val  = lv;
        tick();
        vld[0] = 1'b0;
        lit_en = 1'b0;
    endtask

    function automatic logic [31:0] rnd_opnd(input int xl);
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1 << (xl - 1);
            3:       return (32'd1 << (xl - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        vld     = 4'h0;
        fl      = 4'h0;
        ordy    = 4'hF;
        lit_en  = 1'b0;
        lit_val = 32'd0;
        for (int k = 0; k < 4; k++) begin
            op_s[k]  = MUL_OP_MUL;
            a_s[k]   = 32'd0;
            b_s[k]   = 32'd0;
            tag_s[k] = 5'd0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        dreq(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'hFFFF_FFFE);
        repeat (6) tick();
        dreq(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0000_0001);
        repeat (6) tick();
        dreq(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd3, 1'b1, 32'h4000_0000);
        repeat (6) tick();
        dreq(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFFF);
        repeat (6) tick();
        dreq(MUL_OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 1'b1, 32'hFFFF_FFFE);
        repeat (6) tick();

        // Consumer stalls in DONE, then accepts while a new request lands on the same edge.
        ordy[0] = 1'b0;
        dreq(MUL_OP_MULH, 32'hFFFF_FFF9, 32'h0000_0003, 5'd6, 1'b1, 32'hFFFF_FFFF);
        repeat (8) tick();
        ordy[0] = 1'b1;
        dreq(MUL_OP_MUL, 32'h0000_1234, 32'h0000_0010, 5'd7, 1'b1, 32'h0001_2340);
        repeat (7) tick();

        dreq(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8, 1'b0, 32'd0);
        tick();
        fl[0] = 1'b1;
        tick();
        fl[0] = 1'b0;
        repeat (8) tick();

        // Flush while idle with a request present must not accept it.
        fl[0]  = 1'b1;
        vld[0] = 1'b1;
        tick();
        fl[0]  = 1'b0;
        vld[0] = 1'b0;
        repeat (6) tick();

        dreq(MUL_OP_MULH, 32'h7FFF_FFFF, 32'h8000_0000, 5'd9, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 400; i++) begin
                vld[k]   = ($urandom_range(9) < 7);
                op_s[k]  = 2'($urandom_range(3));
                a_s[k]   = rnd_opnd(cfg_x(k));
                b_s[k]   = rnd_opnd(cfg_x(k));
                tag_s[k] = 5'($urandom);
                fl[k]    = ($urandom_range(99) < 3);
                ordy[k]  = ($urandom_range(3) != 0);
                if ($urandom_range(299) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            vld[k]  = 1'b0;
            fl[k]   = 1'b0;
            ordy[k] = 1'b1;
            repeat (40) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
